// File: rtl/state_pwm_pkg.sv
// rtl/state_pwm_pkg.sv - shared encodings, counter width and decoder band limits for the state PWM link
package state_pwm_pkg;

   localparam int CNT_W = 10;

   typedef enum logic [1:0] {
      ST_BRAKE = 2'b00,
      ST_SHORT = 2'b01,
      ST_OPEN  = 2'b10,
      ST_DRIVE = 2'b11
   } state_t;

   // Highest high-time (in cycles) the decoder maps to each lower band.
   localparam int BAND_BRAKE_MAX = 307;
   localparam int BAND_SHORT_MAX = 409;
   localparam int BAND_OPEN_MAX  = 512;

   function automatic logic [CNT_W-1:0] state_width(
      input state_t           st,
      input logic [CNT_W-1:0] w_brake,
      input logic [CNT_W-1:0] w_short,
      input logic [CNT_W-1:0] w_open,
      input logic [CNT_W-1:0] w_drive
   );
      logic [CNT_W-1:0] w;
      w = w_brake;
      case (st)
         ST_BRAKE: w = w_brake;
         ST_SHORT: w = w_short;
         ST_OPEN:  w = w_open;
         ST_DRIVE: w = w_drive;
         default:  w = w_brake;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/state_pwm_tx_pwm_period_cnt.sv
// rtl/state_pwm_tx_pwm_period_cnt.sv - wrapping period counter with boundary and period_start generation
module pwm_period_cnt
   import state_pwm_pkg::*;
#(
   parameter int PERIOD = 1024
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] cnt_next,
   output logic             boundary,
   output logic             period_start
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   // Reset parks the counter on the last count so the first edge after release wraps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= LAST;
      end else begin
         cnt <= cnt_next;
      end
   end

   always_comb begin
      boundary     = (cnt == LAST);
      cnt_next     = boundary ? '0 : cnt + 1'b1;
      period_start = (cnt == '0);
   end

endmodule

// File: rtl/state_pwm_tx.sv
// rtl/state_pwm_tx.sv - motor-state PWM encoder; optional watchdog under STATE_PWM_TX_WDOG_EN
module state_pwm_tx
   import state_pwm_pkg::*;
#(
   parameter int PERIOD       = 1024,
   parameter int W_BRAKE      = 154,
   parameter int W_SHORT      = 358,
   parameter int W_OPEN       = 460,
   parameter int W_DRIVE      = 768,
   parameter int WDOG_PERIODS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] cmd_state,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       enable,
   output logic       pwm,
   output logic       period_start,
   output logic       wdog_trip
);

   localparam logic [CNT_W-1:0] WB = CNT_W'(W_BRAKE);
   localparam logic [CNT_W-1:0] WS = CNT_W'(W_SHORT);
   localparam logic [CNT_W-1:0] WO = CNT_W'(W_OPEN);
   localparam logic [CNT_W-1:0] WD = CNT_W'(W_DRIVE);

   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] width_next;
   logic             boundary;
   logic             accept;
   logic             wdog_fire;
   logic             pend_vld;
   state_t           pend_st;
   state_t           act_st;
   state_t           act_st_next;
   logic             act_en;
   logic             act_en_next;
   logic             pwm_next;
   logic             pwm_q;

   pwm_period_cnt #(
      .PERIOD (PERIOD)
   ) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .cnt_next     (cnt_next),
      .boundary     (boundary),
      .period_start (period_start)
   );

   assign cmd_ready = !pend_vld;
   assign accept    = cmd_valid && !pend_vld;
   assign pwm       = pwm_q;

   // pwm is registered, so it is computed from the post-edge counter and active state.
   always_comb begin
      act_st_next = act_st;
      act_en_next = act_en;
      if (boundary) begin
         act_en_next = enable;
         if (pend_vld) begin
            act_st_next = pend_st;
         end
         if (wdog_fire) begin
            act_st_next = ST_BRAKE;
         end
      end
      width_next = state_width(act_st_next, WB, WS, WO, WD);
      pwm_next   = act_en_next && (cnt_next < width_next);
   end

   // A command accepted on the boundary edge only fills pending; it never bypasses into active.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_vld <= 1'b0;
         pend_st  <= ST_BRAKE;
         act_st   <= ST_BRAKE;
         act_en   <= 1'b0;
         pwm_q    <= 1'b0;
      end else begin
         act_st <= act_st_next;
         act_en <= act_en_next;
         pwm_q  <= pwm_next;
         if (boundary && pend_vld) begin
            pend_vld <= 1'b0;
         end else if (accept) begin
            pend_vld <= 1'b1;
            pend_st  <= state_t'(cmd_state);
         end
      end
   end

`ifdef STATE_PWM_TX_WDOG_EN
   localparam logic [7:0] WDOG_LIM = 8'(WDOG_PERIODS);

   logic [7:0] wdog_cnt;
   logic       wdog_q;

   // Counter saturates at the limit so the trip fires once per silence interval.
   assign wdog_fire = boundary && !accept && (wdog_cnt != WDOG_LIM) &&
                      (wdog_cnt + 8'd1 == WDOG_LIM);
   assign wdog_trip = wdog_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wdog_cnt <= 8'd0;
         wdog_q   <= 1'b0;
      end else if (accept) begin
         wdog_cnt <= 8'd0;
         wdog_q   <= 1'b0;
      end else if (boundary && (wdog_cnt != WDOG_LIM)) begin
         wdog_cnt <= wdog_cnt + 8'd1;
         if (wdog_fire) begin
            wdog_q <= 1'b1;
         end
      end
   end
`else
   assign wdog_fire = 1'b0;
   assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_state_pwm_tx.sv
// tb/tb_state_pwm_tx.sv - directed self-checking bench for state_pwm_tx
module tb_state_pwm_tx;

   localparam int P = 1024;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] cmd_state;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       enable;
   logic       pwm;
   logic       period_start;
   logic       wdog_trip;

   int total = 0;
   int bad   = 0;
   int hi_acc;
   int ps_acc;
   int ph;

   always #5 clk = ~clk;

   state_pwm_tx #(
      .WDOG_PERIODS (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_state    (cmd_state),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .enable       (enable),
      .pwm          (pwm),
      .period_start (period_start),
      .wdog_trip    (wdog_trip)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      hi_acc += int'(pwm);
      ps_acc += int'(period_start);
      ph++;
      @(negedge clk);
   endtask

   task automatic begin_period();
      hi_acc = 0;
      ps_acc = 0;
      ph     = 0;
   endtask

   task automatic finish_period(input int exp_w, input string tag);
      while (ph < P) tick();
      chk(tag, hi_acc, exp_w);
      chk({tag, "_ps"}, ps_acc, 1);
   endtask

   task automatic measure(input int exp_w, input string tag);
      begin_period();
      finish_period(exp_w, tag);
   endtask

   task automatic send(input logic [1:0] st);
      cmd_valid = 1'b1;
      cmd_state = st;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      enable    = 1'b0;
      cmd_valid = 1'b0;
      cmd_state = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_pwm", pwm, 0);
      chk("rst_ps", period_start, 0);
      chk("rst_rdy", cmd_ready, 1);
      chk("rst_trip", wdog_trip, 0);

      // Release with 11 offered on the first (boundary) edge: it must wait one period.
      reset     = 1'b1;
      enable    = 1'b1;
      cmd_valid = 1'b1;
      cmd_state = 2'b11;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("first_ps", period_start, 1);
      chk("pend_rdy", cmd_ready, 0);
      measure(154, "p0_brake");
      chk("rdy_after_bnd", cmd_ready, 1);
      measure(768, "p1_drive");
      measure(768, "p2_drive");

      begin_period();
      repeat (100) tick();
      send(2'b10);
      chk("open_pend_rdy", cmd_ready, 0);
      finish_period(768, "p3_drive");
      begin_period();
      repeat (200) tick();
      send(2'b01);
      chk("short_pend_rdy", cmd_ready, 0);
      finish_period(460, "mid_open");
      chk("short_rdy_rise", cmd_ready, 1);

      // Back-to-back 00 then 11 with valid held across the boundary.
      begin_period();
      repeat (50) tick();
      cmd_valid = 1'b1;
      cmd_state = 2'b00;
      tick();
      cmd_state = 2'b11;
      tick();
      chk("b2b_stall", cmd_ready, 0);
      finish_period(358, "next_short");
      chk("b2b_rdy_rise", cmd_ready, 1);
      begin_period();
      tick();
      cmd_valid = 1'b0;
      chk("b2b_accept", cmd_ready, 0);
      finish_period(154, "b2b_brake");
      measure(768, "b2b_drive");

      begin_period();
      repeat (300) tick();
      enable = 1'b0;
      finish_period(768, "dis_complete");
      begin_period();
      repeat (100) tick();
      send(2'b11);
      finish_period(0, "dis_off");
      begin_period();
      repeat (500) tick();
      enable = 1'b1;
      finish_period(0, "reen_wait");
      measure(768, "reen");

      // One command then silence for the watchdog.
      begin_period();
      repeat (100) tick();
      send(2'b11);
      finish_period(768, "wd_p0");
      measure(768, "wd_p1");
      measure(768, "wd_p2");
      chk("wd_pre_trip", wdog_trip, 0);
      measure(768, "wd_p3");
`ifdef STATE_PWM_TX_WDOG_EN
      chk("wd_trip", wdog_trip, 1);
`else
      chk("wd_trip", wdog_trip, 0);
`endif
      begin_period();
      repeat (100) tick();
      send(2'b10);
      chk("wd_clear", wdog_trip, 0);
`ifdef STATE_PWM_TX_WDOG_EN
      finish_period(154, "wd_p4");
`else
      finish_period(768, "wd_p4");
`endif
      measure(460, "wd_open");

      begin_period();
      repeat (10) tick();
      send(2'b11);
      finish_period(460, "pre_rst");
      begin_period();
      repeat (300) tick();
      chk("mid_pulse", pwm, 1);
      reset = 1'b0;
      tick();
      chk("rst_drop_pwm", pwm, 0);
      chk("rst_drop_rdy", cmd_ready, 1);
      chk("rst_drop_ps", period_start, 0);
      chk("rst_drop_trip", wdog_trip, 0);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ps", period_start, 1);
      measure(154, "post_rst");
      chk("post_rst_rdy", cmd_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
